// File: rtl/intersection_scheduler.sv
// Two-road intersection sequencer with pedestrian crossing.
// Main road rests in green; side road and walk are served on demand.
module intersection_scheduler #(
  parameter int MAIN_G = 15,
  parameter int MAIN_Y = 5,
  parameter int SIDE_G = 10,
  parameter int SIDE_Y = 5,
  parameter int ALL_R  = 1,
  parameter int PED_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       side_sensor,
  input  logic       ped_req,
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic       walk,
  output logic [3:0] remain,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_MAIN_GRN = 3'd0,
    S_MAIN_YEL = 3'd1,
    S_CLR1     = 3'd2,
    S_SIDE_GRN = 3'd3,
    S_SIDE_YEL = 3'd4,
    S_CLR2     = 3'd5,
    S_WALK     = 3'd6
  } state_e;

  localparam bit PARAMS_OK =
    (MAIN_G >= 1) && (MAIN_G <= 15) &&
    (MAIN_Y >= 1) && (MAIN_Y <= 15) &&
    (SIDE_G >= 1) && (SIDE_G <= 15) &&
    (SIDE_Y >= 1) && (SIDE_Y <= 15) &&
    (ALL_R  >= 1) && (ALL_R  <= 15) &&
    (PED_W  >= 1) && (PED_W  <= 15);

  state_e     state_q, state_d;
  logic [3:0] remain_q, remain_d;
  logic       side_pend_q, side_pend_d;
  logic       ped_pend_q, ped_pend_d;
  logic [2:0] main_q, main_d;
  logic [2:0] side_q, side_lamp_d;
  logic       walk_q, walk_d;
  logic       side_req, ped_req_c, demand, expire, adv;

  function automatic logic [3:0] dur(state_e s);
    case (s)
      S_MAIN_YEL: dur = 4'(MAIN_Y);
      S_CLR1:     dur = 4'(ALL_R);
      S_SIDE_GRN: dur = 4'(SIDE_G);
      S_SIDE_YEL: dur = 4'(SIDE_Y);
      S_CLR2:     dur = 4'(ALL_R);
      S_WALK:     dur = 4'(PED_W);
      default:    dur = 4'(MAIN_G);
    endcase
  endfunction

  // {main, side, walk}
  function automatic logic [6:0] lamps(state_e s);
    case (s)
      S_MAIN_YEL: lamps = {3'b001, 3'b100, 1'b0};
      S_CLR1:     lamps = {3'b100, 3'b100, 1'b0};
      S_SIDE_GRN: lamps = {3'b100, 3'b010, 1'b0};
      S_SIDE_YEL: lamps = {3'b100, 3'b001, 1'b0};
      S_CLR2:     lamps = {3'b100, 3'b100, 1'b0};
      S_WALK:     lamps = {3'b100, 3'b100, 1'b1};
      default:    lamps = {3'b010, 3'b100, 1'b0};
    endcase
  endfunction

  always_comb begin
    side_req  = side_pend_q | side_sensor;
    ped_req_c = ped_pend_q | ped_req;
    demand    = side_req | ped_req_c;
    expire    = (remain_q <= 4'd1);
    adv       = tick & expire;
    state_d   = state_q;
    remain_d  = remain_q;
    if (tick && remain_q != 4'd0) remain_d = remain_q - 4'd1;
    case (state_q)
      S_MAIN_GRN: if (adv && demand) state_d = S_MAIN_YEL;
      S_MAIN_YEL: if (adv) state_d = S_CLR1;
      S_CLR1:     if (adv) state_d = ped_req_c ? S_WALK : S_SIDE_GRN;
      S_WALK:     if (adv) state_d = side_req ? S_SIDE_GRN : S_CLR2;
      S_SIDE_GRN: if (adv) state_d = S_SIDE_YEL;
      S_SIDE_YEL: if (adv) state_d = S_CLR2;
      S_CLR2:     if (adv) state_d = S_MAIN_GRN;
      default:    state_d = S_MAIN_GRN;
    endcase
    if (state_d != state_q) remain_d = dur(state_d);
    // entering the served phase wins over a same-cycle request
    side_pend_d = side_req &
      ~(state_d == S_SIDE_GRN && state_q != S_SIDE_GRN);
    ped_pend_d = ped_req_c &
      ~(state_d == S_WALK && state_q != S_WALK);
    {main_d, side_lamp_d, walk_d} = lamps(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_MAIN_GRN;
      remain_q    <= 4'(MAIN_G);
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      main_q      <= 3'b010;
      side_q      <= 3'b100;
      walk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
      main_q      <= main_d;
      side_q      <= side_lamp_d;
      walk_q      <= walk_d;
    end
  end

  always_ff @(posedge clk) begin
    assert (PARAMS_OK)
      else $error("phase duration parameter outside 1..15");
    if (!rst) begin
      assert (side_q == 3'b100 || main_q == 3'b100)
        else $error("conflicting greens");
    end
  end

  assign main_rgy = main_q;
  assign side_rgy = side_q;
  assign walk     = walk_q;
  assign remain   = remain_q;
  assign phase    = state_q;

endmodule
